reg_write_scheduler: RTL and testbench

Write-port scheduler and scoreboard for the 2-read/1-write register file. Arbitrates the single write port round-robin between NUM_SRC writeback sources (ALU, LSU, multiply/divide) over a valid/ready handshake and drives a registered write port into the register file. Keeps a per-register pending-write scoreboard so issue logic can stall on RAW hazards (busy query) and WAW hazards (refused reservation).

---
 rtl/reg_sched_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 57 +++++
 rtl/reg_write_scheduler.sv | 108 ++++++++++
 tb/tb_reg_write_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_sched_pkg.sv
// Shared definitions for the register-file write scheduler: default sizes,
// writeback source indices and the write-request record.
package reg_sched_pkg;

    localparam int NUM_SRC_DEFAULT = 3;
    localparam int REG_DATA_WIDTH  = 32;
    localparam int REG_ADDR_WIDTH  = 5;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_MDU = 2;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [REG_DATA_WIDTH-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from the
// pointer with wrap; the pointer moves past the winner when accept_i is high.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          accept_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] cand;
    logic          found;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int off = 0; off < N; off++) begin
            if (int'(rr_q) + off >= N) begin
                cand = IW'(int'(rr_q) + off - N);
            end else begin
                cand = IW'(int'(rr_q) + off);
            end
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                grant_o[cand]  = 1'b1;
                idx_o          = cand;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (accept_i) begin
            rr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + IW'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/reg_write_scheduler.sv
// Write-port scheduler for the 2R/1W register file: round-robin writeback
// arbitration, registered write port and a per-register pending scoreboard.
module reg_write_scheduler
    import reg_sched_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int NUM_SRC    = NUM_SRC_DEFAULT
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic [NUM_SRC-1:0]            i_SrcValid,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] i_SrcAddr,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] i_SrcData,
    output logic [NUM_SRC-1:0]            o_SrcReady,
    input  logic                          i_RsvValid,
    input  logic [ADDR_WIDTH-1:0]         i_RsvAddr,
    output logic                          o_RsvReady,
    input  logic [ADDR_WIDTH-1:0]         i_QryAddrA,
    input  logic [ADDR_WIDTH-1:0]         i_QryAddrB,
    output logic                          o_BusyA,
    output logic                          o_BusyB,
    output logic [ADDR_WIDTH-1:0]         o_WrAddr,
    output logic [DATA_WIDTH-1:0]         o_WrData,
    output logic                          o_WrEnable
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  transfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic                  rsv_accept;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .clk      (i_Clock),
        .rst_n    (i_Reset),
        .req_i    (i_SrcValid),
        .accept_i (transfer),
        .grant_o  (grant),
        .idx_o    (grant_idx)
    );

    // Grants only go to valid sources, so any visible ready is a transfer.
    assign o_SrcReady = grant & {NUM_SRC{i_Reset}};
    assign transfer   = |o_SrcReady;
    assign sel_addr   = i_SrcAddr[int'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data   = i_SrcData[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        wr_en_d   = transfer;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (transfer) begin
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
        end
    end

    // A pending register is always refused, so a clear and a set never
    // target the same bit in one cycle; bit 0 is kept permanently clear.
    assign rsv_accept = i_Reset & i_RsvValid &
                        ((i_RsvAddr == '0) | ~pending_q[i_RsvAddr]);
    assign o_RsvReady = rsv_accept;

    always_comb begin
        pending_d = pending_q;
        if (wr_en_q && (wr_addr_q != '0)) begin
            pending_d[wr_addr_q] = 1'b0;
        end
        if (rsv_accept && (i_RsvAddr != '0)) begin
            pending_d[i_RsvAddr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    assign o_BusyA = (i_QryAddrA != '0) & pending_q[i_QryAddrA];
    assign o_BusyB = (i_QryAddrB != '0) & pending_q[i_QryAddrB];

    // NOTE: the scoreboard is a small flop array, not a RAM, so it is reset;
    // a stale pending bit after reset would stall issue forever.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
        end
    end

    assign o_WrEnable = wr_en_q;
    assign o_WrAddr   = wr_addr_q;
    assign o_WrData   = wr_data_q;

endmodule

// File: tb/tb_reg_write_scheduler.sv
// Self-checking bench for reg_write_scheduler: directed scenarios plus
// randomized traffic compared each cycle against a cycle-level reference model.
module tb_reg_write_scheduler;
    import reg_sched_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 3;
    localparam int NR = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NS-1:0]    src_valid;
    logic [NS*AW-1:0] src_addr;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]    src_ready;
    logic             rsv_valid;
    logic [AW-1:0]    rsv_addr;
    logic             rsv_ready;
    logic [AW-1:0]    qa, qb;
    logic             busy_a, busy_b;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             wr_en;

    reg_write_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SRC(NS)) dut (
        .i_Clock    (clk),
        .i_Reset    (rst_n),
        .i_SrcValid (src_valid),
        .i_SrcAddr  (src_addr),
        .i_SrcData  (src_data),
        .o_SrcReady (src_ready),
        .i_RsvValid (rsv_valid),
        .i_RsvAddr  (rsv_addr),
        .o_RsvReady (rsv_ready),
        .i_QryAddrA (qa),
        .i_QryAddrB (qb),
        .o_BusyA    (busy_a),
        .o_BusyB    (busy_b),
        .o_WrAddr   (wr_addr),
        .o_WrData   (wr_data),
        .o_WrEnable (wr_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending set, rotation pointer, write-port register.
    logic [NR-1:0] m_pend;
    int            m_rr;
    logic          m_wr_en;
    wr_req_t       m_wr;
    int            last_grant;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend     = '0;
        m_rr       = 0;
        m_wr_en    = 1'b0;
        m_wr       = '0;
        last_grant = -1;
    endtask

    task automatic set_src(input int s, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        src_valid[s]         = v;
        src_addr[s*AW +: AW] = a;
        src_data[s*DW +: DW] = d;
    endtask

    // One clock: check all outputs at the falling edge, advance the model,
    // and return just after the next rising edge.
    task automatic cycle();
        int            g;
        int            s;
        logic [NS-1:0] eg;
        logic          ers;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NS; k++) begin
            s = (m_rr + k) % NS;
            if (g < 0 && src_valid[s]) g = s;
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        ers = rsv_valid && (rsv_addr == 0 || !m_pend[rsv_addr]);
        check("grant", src_ready, eg);
        check("rsv_ready", rsv_ready, ers);
        check("busy_a", busy_a, (qa != 0) && m_pend[qa]);
        check("busy_b", busy_b, (qb != 0) && m_pend[qb]);
        check("wr_en", wr_en, m_wr_en);
        check("wr_addr", wr_addr, m_wr.addr);
        check("wr_data", wr_data, m_wr.data);
        if (m_wr_en && m_wr.addr != 0) m_pend[m_wr.addr] = 1'b0;
        if (ers && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
        if (g >= 0) begin
            m_rr       = (g + 1) % NS;
            m_wr_en    = 1'b1;
            m_wr.addr  = src_addr[g*AW +: AW];
            m_wr.data  = src_data[g*DW +: DW];
            last_grant = g;
        end else begin
            m_wr_en    = 1'b0;
            last_grant = -1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        src_valid = '0;
        src_addr  = '0;
        src_data  = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        qa        = '0;
        qb        = '0;
        model_reset();

        // Reset state, with a reservation attempt that must be ignored.
        #12;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd4;
        #1;
        check("reset_wr_en", wr_en, 1'b0);
        check("reset_wr_addr", wr_addr, '0);
        check("reset_rsv_ready", rsv_ready, 1'b0);
        rsv_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin with all three sources valid.
        set_src(SRC_ALU, 1'b1, 5'd1, 32'hA);
        set_src(SRC_LSU, 1'b1, 5'd2, 32'hB);
        set_src(SRC_MDU, 1'b1, 5'd3, 32'hC);
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("rr_grant", last_grant, k % 3);
            check("rr_wraddr", wr_addr, (k % 3) + 1);
        end
        src_valid = '0;
        cycle();

        // RAW timing on x7.
        qa        = 5'd7;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        cycle();
        rsv_valid = 1'b0;
        #1;
        check("raw_busy_t1", busy_a, 1'b1);
        repeat (3) cycle();
        set_src(SRC_LSU, 1'b1, 5'd7, 32'hDEAD);
        cycle();
        check("raw_lsu_grant", last_grant, SRC_LSU);
        src_valid = '0;
        #1;
        check("raw_wr_en_t5", wr_en, 1'b1);
        check("raw_wr_addr_t5", wr_addr, 5'd7);
        check("raw_busy_t5", busy_a, 1'b1);
        cycle();
        check("raw_busy_t6", busy_a, 1'b0);

        // WAW refusal on x9, including the clear cycle.
        rsv_valid = 1'b1;
        rsv_addr  = 5'd9;
        cycle();
        set_src(SRC_ALU, 1'b1, 5'd9, 32'h99);
        #1;
        check("waw_refused", rsv_ready, 1'b0);
        cycle();
        src_valid = '0;
        #1;
        check("waw_clear_wr_en", wr_en, 1'b1);
        check("waw_at_clear", rsv_ready, 1'b0);
        cycle();
        #1;
        check("waw_accept", rsv_ready, 1'b1);
        cycle();
        rsv_valid = 1'b0;

        // x0: reservation accepted, never busy, write passes through.
        qa        = 5'd0;
        qb        = 5'd9;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd0;
        #1;
        check("x0_rsv_ready", rsv_ready, 1'b1);
        cycle();
        rsv_valid = 1'b0;
        #1;
        check("x0_busy", busy_a, 1'b0);
        set_src(SRC_MDU, 1'b1, 5'd0, 32'hFFFF);
        cycle();
        src_valid = '0;
        #1;
        check("x0_wr_en", wr_en, 1'b1);
        check("x0_wr_addr", wr_addr, 5'd0);
        check("x0_wr_data", wr_data, 32'hFFFF);
        check("x0_sb_x9", busy_b, 1'b1);
        cycle();

        // Only source 2 valid while the pointer is 0, then pointer back at 0.
        set_src(SRC_MDU, 1'b1, 5'd10, 32'h22);
        cycle();
        check("rr_only_src2", last_grant, SRC_MDU);
        src_valid = '1;
        cycle();
        check("rr_wrap_to0", last_grant, SRC_ALU);
        src_valid = '0;
        cycle();

        // Clear of x3 and reservation of x4 in the same cycle.
        rsv_valid = 1'b1;
        rsv_addr  = 5'd3;
        cycle();
        rsv_valid = 1'b0;
        set_src(SRC_ALU, 1'b1, 5'd3, 32'h33);
        cycle();
        src_valid = '0;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd4;
        cycle();
        rsv_valid = 1'b0;
        qa        = 5'd3;
        qb        = 5'd4;
        #1;
        check("sim_clear_x3", busy_a, 1'b0);
        check("sim_set_x4", busy_b, 1'b1);
        cycle();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            if (last_grant >= 0) src_valid[last_grant] = 1'b0;
            for (int s = 0; s < NS; s++) begin
                if (!src_valid[s] && ($urandom_range(0, 1) == 1)) begin
                    set_src(s, 1'b1, AW'($urandom), $urandom);
                end
            end
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_addr  = AW'($urandom);
            qa        = AW'($urandom);
            qb        = AW'($urandom);
            cycle();
        end

        // Asynchronous reset mid-transfer with x5 pending.
        src_valid = '0;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd5;
        cycle();
        while (last_grant >= 0 || m_pend[5] == 1'b0) begin
            src_valid = '0;
            rsv_valid = 1'b1;
            rsv_addr  = 5'd5;
            cycle();
        end
        rsv_valid = 1'b0;
        qa        = 5'd5;
        set_src(SRC_ALU, 1'b1, 5'd1, 32'h11);
        set_src(SRC_LSU, 1'b1, 5'd2, 32'h22);
        set_src(SRC_MDU, 1'b1, 5'd3, 32'h33);
        cycle();
        #1;
        check("pre_reset_busy5", busy_a, 1'b1);
        rst_n     = 1'b0;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd6;
        #1;
        check("arst_wr_en", wr_en, 1'b0);
        check("arst_wr_addr", wr_addr, '0);
        check("arst_wr_data", wr_data, '0);
        check("arst_src_ready", src_ready, '0);
        check("arst_rsv_ready", rsv_ready, 1'b0);
        check("arst_busy5", busy_a, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsv_valid = 1'b0;
        #1;
        check("post_reset_busy5", busy_a, 1'b0);
        check("post_reset_rr0", src_ready, 3'b001);
        cycle();
        src_valid = '0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
